// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the sync_fifo write-port arbiter.
//   - arb_state_t : arbiter FSM state (IDLE waits for a winner, BURST holds
//                   the write port for one owner).
//   - FIFO_DATA_W : native word width of sync_fifo DATAIN.
//   - rr_next     : round-robin successor of an id, wrapping n-1 -> 0.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_DATA_W = 32;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority finder. Scans req starting at rr_ptr,
//   then rr_ptr+1, ... (mod NUM_REQ) and reports the first active requester.
// Ports
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  ID_W     id with highest priority this cycle
//   found     out 1        at least one request is active
//   winner_id out ID_W     first active id in rotating order (0 when !found)
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    winner_id
);

    always_comb begin : scan
        logic [ID_W-1:0] idx;
        found     = 1'b0;
        winner_id = '0;
        idx       = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[idx]) begin
                found     = 1'b1;
                winner_id = idx;
            end
            idx = ID_W'(rr_next(32'(idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of sync_fifo among NUM_REQ producers.
//   Round-robin grants with bursts of up to MAX_BURST words; a burst ends
//   with one bubble cycle, after which priority moves to owner+1.
//   Back-pressure is taken directly from the FIFO full flag.
// Ports
//   clock    in   1               rising-edge clock
//   reset    in   1               synchronous, active-high
//   req      in   NUM_REQ         producer i has a word on slice i
//   req_data in   NUM_REQ*DATA_W  slice i = [i*DATA_W +: DATA_W]
//   ack      out  NUM_REQ         one-hot/zero, word i written this edge
//   full     in   1               sync_fifo full
//   wn       out  1               sync_fifo write enable (= |ack)
//   DATAIN   out  DATA_W          sync_fifo write data, 0 when wn=0
//   busy     out  1               high while a burst is in progress
//   owner    out  ID_W            current / last granted id
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      full,
    output logic                      wn,
    output logic [DATA_W-1:0]         DATAIN,
    output logic                      busy,
    output logic [ID_W-1:0]           owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic             grant_idle;
    logic             grant_burst;
    logic             burst_end;
    logic [ID_W-1:0]  sel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .found     (found),
        .winner_id (winner)
    );

    // Write decision is purely combinational so a word is written on the
    // same edge it is acked; reset masks it so nothing leaks out while held.
    always_comb begin
        grant_idle  = !reset && (state == IDLE) && found && !full;
        grant_burst = !reset && (state == BURST) && req[owner] && (cnt < CNT_MAX) && !full;
        // Dropping req wins over a simultaneous full stall.
        burst_end   = (state == BURST) && (!req[owner] || (cnt == CNT_MAX));
        sel         = (state == IDLE) ? winner : owner;

        ack = '0;
        if (grant_idle || grant_burst) begin
            ack[sel] = 1'b1;
        end
        wn     = grant_idle || grant_burst;
        DATAIN = wn ? req_data[32'(sel)*DATA_W +: DATA_W] : '0;
        busy   = (state == BURST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            owner  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_idle) begin
                        owner <= winner;
                        cnt   <= CNT_W'(1);
                        if (MAX_BURST == 1) begin
                            rr_ptr <= ID_W'(rr_next(32'(winner), NUM_REQ));
                        end else begin
                            state <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        // Bubble cycle: hand priority to the next id.
                        rr_ptr <= ID_W'(rr_next(32'(owner), NUM_REQ));
                        cnt    <= '0;
                        state  <= IDLE;
                    end else if (grant_burst) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              full;
    logic              wn;
    logic [DW-1:0]     DATAIN;
    logic              busy;
    logic [1:0]        owner;

    // second instance, single-word grants
    logic [NREQ-1:0]   req2;
    logic [NREQ*DW-1:0] data2;
    logic [NREQ-1:0]   ack2;
    logic              full2;
    logic              wn2;
    logic [DW-1:0]     DATAIN2;
    logic              busy2;
    logic [1:0]        owner2;

    // 8-deep FIFO model
    logic [DW-1:0] fmem [8];
    logic [2:0]    fwp, frp;
    logic [3:0]    fcnt;
    logic          fifo_clr, rd, tb_push;
    logic [DW-1:0] tb_pdata;
    logic          f_push, f_pop;
    logic [DW-1:0] f_pdat, fdout;

    int tests = 0;
    int fails = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(4), .ID_W(2)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .full(full), .wn(wn), .DATAIN(DATAIN), .busy(busy), .owner(owner));

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(1), .ID_W(2)) u_rr (
        .clock(clock), .reset(reset), .req(req2), .req_data(data2), .ack(ack2),
        .full(full2), .wn(wn2), .DATAIN(DATAIN2), .busy(busy2), .owner(owner2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign f_push = wn | tb_push;
    assign f_pdat = wn ? DATAIN : tb_pdata;
    assign f_pop  = rd && (fcnt != 4'd0);
    assign full   = (fcnt == 4'd8);
    assign fdout  = fmem[frp];

    always @(posedge clock) begin
        if (fifo_clr) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= '0;
        end else begin
            if (f_push) begin
                fmem[fwp] <= f_pdat;
                fwp       <= fwp + 3'd1;
            end
            if (f_pop) frp <= frp + 3'd1;
            fcnt <= fcnt + {3'b0, f_push} - {3'b0, f_pop};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        chk("safe_wn_full", {63'b0, wn & full}, 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic setd(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic readchk(input string tag, input logic [DW-1:0] e);
        rd = 1'b1;
        #1;
        chk(tag, fdout, e);
        tick();
        rd = 1'b0;
    endtask

    int            idx;
    logic          exp_w;
    logic [DW-1:0] t2d [7];

    initial begin
        t2d = '{32'd10, 32'd15, 32'd20, 32'd30, 32'd35, 32'd40, 32'd45};
        reset = 1'b1; fifo_clr = 1'b1; rd = 1'b0; tb_push = 1'b0; tb_pdata = '0;
        req = 4'b1111; req_data = '0;
        for (int i = 0; i < NREQ; i++) setd(i, 32'hA0 + 32'(i));
        req2 = '0; data2 = '0; full2 = 1'b0;

        // ---- 1: reset ----
        tick();
        chk("rst1_ack", ack, 0); chk("rst1_wn", wn, 0);
        chk("rst1_data", DATAIN, 0); chk("rst1_busy", busy, 0);
        fifo_clr = 1'b0;
        tick();
        chk("rst2_ack", ack, 0); chk("rst2_wn", wn, 0);
        chk("rst2_data", DATAIN, 0); chk("rst2_busy", busy, 0); chk("rst2_owner", owner, 0);
        reset = 1'b0; #1;
        chk("rel_ack", ack, 4'b0001); chk("rel_wn", wn, 1); chk("rel_data", DATAIN, 32'hA0);
        tick();
        req = '0; #1;
        chk("rel_bubble_busy", busy, 1); chk("rel_bubble_ack", ack, 0); chk("rel_owner", owner, 0);
        tick();
        chk("rel_idle_busy", busy, 0);
        fifo_clr = 1'b1; tick(); fifo_clr = 1'b0;

        // ---- 2: single producer, burst of 4 then bubble ----
        req = 4'b0100; idx = 0;
        for (int c = 0; c < 8; c++) begin
            setd(2, t2d[idx]); #1;
            exp_w = (c != 4);
            chk("t2_wn", wn, exp_w);
            chk("t2_ack", ack, exp_w ? 4'b0100 : 4'b0000);
            chk("t2_data", DATAIN, exp_w ? t2d[idx] : 32'd0);
            chk("t2_busy", busy, ((c >= 1 && c <= 4) || c >= 6) ? 1 : 0);
            tick();
            if (exp_w) idx++;
        end
        req = '0; #1;
        chk("t2_end_busy", busy, 1); chk("t2_end_ack", ack, 0);
        tick();
        chk("t2_idle", busy, 0); chk("t2_owner", owner, 2); chk("t2_fcnt", fcnt, 7);
        for (int i = 0; i < 7; i++) readchk("t2_read", t2d[i]);

        // ---- 4: full stall (rr_ptr=3 -> producer 1 wins) ----
        tb_push = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tb_pdata = 32'h700 + 32'(i);
            tick();
        end
        tb_push = 1'b0;
        req = 4'b0010; setd(1, 32'hB0); #1;
        chk("t4_first_ack", ack, 4'b0010); chk("t4_first_data", DATAIN, 32'hB0);
        tick();
        setd(1, 32'hB1); #1;
        chk("t4_stall_ack", ack, 0); chk("t4_stall_wn", wn, 0); chk("t4_stall_busy", busy, 1);
        tick();
        chk("t4_stall2_ack", ack, 0);
        rd = 1'b1; #1;
        chk("t4_rd1_ack", ack, 0);
        tick();
        chk("t4_res_ack", ack, 4'b0010); chk("t4_res_data", DATAIN, 32'hB1);
        tick();
        rd = 1'b0; setd(1, 32'hB2); #1;
        chk("t4_b2_ack", ack, 4'b0010); chk("t4_b2_data", DATAIN, 32'hB2);
        tick();
        setd(1, 32'hB3); rd = 1'b1; #1;
        chk("t4_stall3_ack", ack, 0); chk("t4_stall3_busy", busy, 1);
        tick();
        rd = 1'b0; #1;
        chk("t4_b3_ack", ack, 4'b0010); chk("t4_b3_data", DATAIN, 32'hB3);
        tick();
        setd(1, 32'hB4); #1;
        chk("t4_max_ack", ack, 0); chk("t4_max_busy", busy, 1);
        tick();
        chk("t4_idlefull_ack", ack, 0); chk("t4_idlefull_busy", busy, 0);
        tick();
        chk("t4_idlefull2_ack", ack, 0); chk("t4_owner", owner, 1);
        req = '0;
        readchk("t4_r0", 32'h703); readchk("t4_r1", 32'h704);
        readchk("t4_r2", 32'h705); readchk("t4_r3", 32'h706);
        readchk("t4_r4", 32'hB0);  readchk("t4_r5", 32'hB1);
        readchk("t4_r6", 32'hB2);  readchk("t4_r7", 32'hB3);
        chk("t4_empty", fcnt, 0);

        // ---- 5: early drop by owner 3, wrap to 0 ----
        req = 4'b1000; setd(3, 32'hC0); #1;
        chk("t5_c0_ack", ack, 4'b1000); chk("t5_c0_data", DATAIN, 32'hC0);
        tick();
        setd(3, 32'hC1); #1;
        chk("t5_c1_ack", ack, 4'b1000); chk("t5_c1_busy", busy, 1);
        tick();
        req = 4'b0001; setd(0, 32'hD0); #1;
        chk("t5_drop_ack", ack, 0); chk("t5_drop_busy", busy, 1);
        tick();
        chk("t5_wrap_ack", ack, 4'b0001); chk("t5_wrap_data", DATAIN, 32'hD0);
        chk("t5_owner3", owner, 3);
        tick();
        chk("t5_owner0", owner, 0);
        req = '0; #1;
        tick(); tick();
        fifo_clr = 1'b1; tick(); fifo_clr = 1'b0;

        // ---- 6: reset mid-burst (rr_ptr=1) ----
        req = 4'b0100; setd(2, 32'hE0); #1;
        chk("t6_e0_ack", ack, 4'b0100);
        tick();
        setd(2, 32'hE1); #1;
        chk("t6_e1_ack", ack, 4'b0100);
        tick();
        chk("t6_fcnt_pre", fcnt, 2);
        reset = 1'b1; setd(2, 32'hE2); #1;
        chk("t6_rst_ack", ack, 0); chk("t6_rst_wn", wn, 0); chk("t6_rst_data", DATAIN, 0);
        tick();
        chk("t6_busy", busy, 0); chk("t6_fcnt_post", fcnt, 2); chk("t6_owner", owner, 0);
        reset = 1'b0; req = 4'b0101; setd(0, 32'hF0); #1;
        chk("t6_ptr0_ack", ack, 4'b0001); chk("t6_ptr0_data", DATAIN, 32'hF0);
        tick();
        req = '0; #1;
        tick(); tick();

        // ---- 3: round-robin, MAX_BURST=1 ----
        for (int i = 0; i < NREQ; i++) data2[i*DW +: DW] = 32'h300 + 32'(i);
        req2 = 4'b1111; #1;
        for (int k = 0; k < 6; k++) begin
            chk("t3_ack", ack2, 4'b0001 << (k % 4));
            chk("t3_wn", wn2, 1);
            chk("t3_busy", busy2, 0);
            chk("t3_data", DATAIN2, 32'h300 + 32'(k % 4));
            tick();
        end
        full2 = 1'b1; #1;
        chk("t3_full_ack", ack2, 0); chk("t3_full_wn", wn2, 0);
        tick();
        full2 = 1'b0; #1;
        chk("t3_resume_ack", ack2, 4'b0100); chk("t3_resume_data", DATAIN2, 32'h302);
        tick();
        chk("t3_owner", owner2, 2);
        req2 = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
